// File: rtl/exe_md_pkg.sv
// Shared definitions for the execute-stage multiply/divide slice.
//   - md op encodings carried on in_op
//   - mul/div sequencer state enum
//   - all-ones constant used as the divide-by-zero quotient
//   - small op-classification helpers
package exe_md_pkg;

  localparam logic [2:0] MD_NONE  = 3'd0;
  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MTHI  = 3'd5;
  localparam logic [2:0] MD_MTLO  = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } md_state_e;

  // Wide enough for any sane DATA_W; users slice [DATA_W-1:0].
  localparam logic [127:0] DIV0_QUO = '1;

  function automatic logic is_mul(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

  function automatic logic is_div(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_muldiv(input logic [2:0] op);
    return is_mul(op) || is_div(op);
  endfunction

endpackage

// File: rtl/exe_muldiv_divider.sv
// md_divider: iterative restoring divider, one quotient bit per cycle on
// operand magnitudes, with sign fix-up applied on the outputs.
//   clk, rst_n   : clock, synchronous active-low reset
//   start        : capture a/b and begin (first quotient bit resolved on this edge)
//   signed_en    : treat a/b as two's complement
//   a, b         : dividend, divisor
//   busy         : iterations still pending
//   done         : quo/rem valid (DATA_W cycles of work after start)
//   quo, rem     : quotient / remainder; b==0 gives quo=all ones, rem=a
module md_divider
  import exe_md_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              signed_en,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] quo,
  output logic [DATA_W-1:0] rem
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [DATA_W-1:0] q_r, r_r, d_r, a_r;
  logic              neg_q, neg_r, div0, done_r;
  logic [CNT_W-1:0]  cnt;

  logic              a_neg, b_neg;
  logic [DATA_W-1:0] a_mag, b_mag;
  logic [2*DATA_W-1:0] first_step, next_step;

  // One restoring step: shift the next dividend bit into the partial
  // remainder, subtract the divisor if it fits, record the quotient bit.
  function automatic logic [2*DATA_W-1:0] div_step(input logic [DATA_W-1:0] r,
                                                   input logic [DATA_W-1:0] q,
                                                   input logic [DATA_W-1:0] d);
    logic [DATA_W:0] t;
    logic            ge;
    t  = {r, q[DATA_W-1]};
    ge = (t >= {1'b0, d});
    if (ge) t = t - {1'b0, d};
    return {t[DATA_W-1:0], q[DATA_W-2:0], ge};
  endfunction

  assign a_neg = signed_en & a[DATA_W-1];
  assign b_neg = signed_en & b[DATA_W-1];
  assign a_mag = a_neg ? (~a + 1'b1) : a;
  assign b_mag = b_neg ? (~b + 1'b1) : b;

  // The start edge already performs the first iteration, so the final
  // result is stable one cycle before DATA_W cycles have elapsed.
  assign first_step = div_step('0, a_mag, b_mag);
  assign next_step  = div_step(r_r, q_r, d_r);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_r    <= '0;
      r_r    <= '0;
      d_r    <= '0;
      a_r    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      div0   <= 1'b0;
      done_r <= 1'b0;
      cnt    <= '0;
    end else if (start) begin
      {r_r, q_r} <= first_step;
      d_r    <= b_mag;
      a_r    <= a;
      neg_q  <= a_neg ^ b_neg;
      neg_r  <= a_neg;
      div0   <= (b == '0);
      done_r <= 1'b0;
      cnt    <= CNT_W'(DATA_W - 1);
    end else if (cnt != '0) begin
      {r_r, q_r} <= next_step;
      cnt        <= cnt - CNT_W'(1);
      if (cnt == CNT_W'(1)) done_r <= 1'b1;
    end
  end

  assign busy = (cnt != '0);
  assign done = done_r;
  assign quo  = div0 ? DIV0_QUO[DATA_W-1:0] : (neg_q ? (~q_r + 1'b1) : q_r);
  assign rem  = div0 ? a_r                  : (neg_r ? (~r_r + 1'b1) : r_r);

endmodule

// File: rtl/exe_muldiv_stage.sv
// exe_muldiv_stage: ID->EXE pipeline register with a multi-cycle
// multiply/divide unit and architectural HI/LO.
//   clk, rst_n          : clock, synchronous active-low reset
//   flush               : drop the held instruction, abort mul/div
//   in_valid/in_allowin : upstream handshake
//   in_op/src0/src1     : md op and operands
//   in_payload          : opaque execute bundle, passed through unchanged
//   out_allowin/out_valid/out_payload : downstream handshake
//   hi, lo              : architectural HI/LO (written only on handoff)
//   md_busy             : sequencer is iterating
module exe_muldiv_stage
  import exe_md_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int PAYLOAD_W = 64,
  parameter int MUL_LAT   = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_allowin,
  input  logic [2:0]           in_op,
  input  logic [DATA_W-1:0]    in_src0,
  input  logic [DATA_W-1:0]    in_src1,
  input  logic [PAYLOAD_W-1:0] in_payload,
  input  logic                 out_allowin,
  output logic                 out_valid,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic [DATA_W-1:0]    hi,
  output logic [DATA_W-1:0]    lo,
  output logic                 md_busy
);

  localparam int CNT_MAX = (DATA_W > MUL_LAT) ? DATA_W : MUL_LAT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int SR_N    = (MUL_LAT > 1) ? MUL_LAT - 1 : 1;

  logic                 valid_r;
  logic [2:0]           op_r;
  logic [DATA_W-1:0]    src0_r, src1_r, hi_r, lo_r, res_hi, res_lo;
  logic [PAYLOAD_W-1:0] payload_r;

  md_state_e        state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n, start_cnt;
  logic             res_lat;

  logic ready, load, start, handoff;

  assign ready      = !is_muldiv(op_r) || (state == ST_DONE);
  assign in_allowin = !valid_r || (ready && out_allowin);
  assign load       = in_allowin && in_valid;
  assign handoff    = valid_r && ready && out_allowin && !flush;
  // A load while DONE implies the held op hands off on the same edge,
  // so a new mul/div can start straight from DONE.
  assign start      = load && !flush && is_muldiv(in_op);
  assign start_cnt  = is_div(in_op) ? CNT_W'(DATA_W) : CNT_W'(MUL_LAT);

  // Multiplier: combinational product on the held operands, delayed so the
  // result is captured exactly MUL_LAT cycles after the operands arrive.
  logic [2*DATA_W-1:0] mul_a, mul_b, mul_prod, mul_tap;
  logic [2*DATA_W-1:0] mul_sr [SR_N];

  assign mul_a    = (op_r == MD_MULT) ? {{DATA_W{src0_r[DATA_W-1]}}, src0_r}
                                      : {{DATA_W{1'b0}}, src0_r};
  assign mul_b    = (op_r == MD_MULT) ? {{DATA_W{src1_r[DATA_W-1]}}, src1_r}
                                      : {{DATA_W{1'b0}}, src1_r};
  assign mul_prod = mul_a * mul_b;

  generate
    if (MUL_LAT == 1) begin : g_mul_direct
      assign mul_tap = mul_prod;
    end else begin : g_mul_delay
      assign mul_tap = mul_sr[MUL_LAT-2];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < SR_N; i++) mul_sr[i] <= '0;
    end else begin
      mul_sr[0] <= mul_prod;
      for (int i = 1; i < SR_N; i++) mul_sr[i] <= mul_sr[i-1];
    end
  end

  // Divider is started from the raw inputs on the load edge so it runs in
  // lock-step with the sequencer counter.
  logic [DATA_W-1:0] div_quo, div_rem;
  logic              div_busy, div_done, div_unused;

  md_divider #(.DATA_W(DATA_W)) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start && is_div(in_op)),
    .signed_en (in_op == MD_DIV),
    .a         (in_src0),
    .b         (in_src1),
    .busy      (div_busy),
    .done      (div_done),
    .quo       (div_quo),
    .rem       (div_rem)
  );

  assign div_unused = div_busy ^ div_done;

  // Sequencer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    res_lat = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_n = ST_BUSY;
          cnt_n   = start_cnt;
        end
      end
      ST_BUSY: begin
        cnt_n = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          state_n = ST_DONE;
          res_lat = 1'b1;
        end
      end
      ST_DONE: begin
        if (handoff) begin
          if (start) begin
            state_n = ST_BUSY;
            cnt_n   = start_cnt;
          end else begin
            state_n = ST_IDLE;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
    if (flush) begin
      state_n = ST_IDLE;
      cnt_n   = '0;
      res_lat = 1'b0;
    end
  end

  // Pipeline register, result latch and HI/LO commit
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_r   <= 1'b0;
      op_r      <= MD_NONE;
      src0_r    <= '0;
      src1_r    <= '0;
      payload_r <= '0;
      res_hi    <= '0;
      res_lo    <= '0;
      hi_r      <= '0;
      lo_r      <= '0;
    end else begin
      if (flush)           valid_r <= 1'b0;
      else if (in_allowin) valid_r <= in_valid;

      if (load) begin
        op_r      <= in_op;
        src0_r    <= in_src0;
        src1_r    <= in_src1;
        payload_r <= in_payload;
      end

      if (res_lat) begin
        if (is_div(op_r)) {res_hi, res_lo} <= {div_rem, div_quo};
        else              {res_hi, res_lo} <= mul_tap;
      end

      // HI/LO only change when the instruction actually leaves the stage.
      if (handoff) begin
        if (is_muldiv(op_r)) begin
          hi_r <= res_hi;
          lo_r <= res_lo;
        end else if (op_r == MD_MTHI) begin
          hi_r <= src0_r;
        end else if (op_r == MD_MTLO) begin
          lo_r <= src0_r;
        end
      end
    end
  end

  assign out_valid   = valid_r && ready;
  assign out_payload = payload_r;
  assign hi          = hi_r;
  assign lo          = lo_r;
  assign md_busy     = (state == ST_BUSY);

endmodule

// File: tb/tb_exe_muldiv_stage.sv
// Self-checking bench for exe_muldiv_stage: directed cases plus random ops,
// compared against an arithmetic HI/LO model.
module tb_exe_muldiv_stage;

  localparam int W  = 32;
  localparam int PW = 64;
  localparam int ML = 2;

  logic          clk, rst_n, flush, in_valid, in_allowin, out_allowin;
  logic          out_valid, md_busy;
  logic [2:0]    in_op;
  logic [W-1:0]  in_src0, in_src1, hi, lo;
  logic [PW-1:0] in_payload, out_payload;

  exe_muldiv_stage #(.DATA_W(W), .PAYLOAD_W(PW), .MUL_LAT(ML)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_allowin  (in_allowin),
    .in_op       (in_op),
    .in_src0     (in_src0),
    .in_src1     (in_src1),
    .in_payload  (in_payload),
    .out_allowin (out_allowin),
    .out_valid   (out_valid),
    .out_payload (out_payload),
    .hi          (hi),
    .lo          (lo),
    .md_busy     (md_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  logic [W-1:0] hi_m = '0;
  logic [W-1:0] lo_m = '0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int exp_lat(input logic [2:0] op);
    if (op == 3'd1 || op == 3'd2) return ML;
    if (op == 3'd3 || op == 3'd4) return W;
    return 0;
  endfunction

  // Architectural effect of one committed instruction.
  task automatic model_commit(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb;
    logic [63:0] p;
    int ia, ib;
    case (op)
      3'd1: begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p = 64'(sa * sb);
        hi_m = p[63:32]; lo_m = p[31:0];
      end
      3'd2: begin
        p = {32'b0, a} * {32'b0, b};
        hi_m = p[63:32]; lo_m = p[31:0];
      end
      3'd3: begin
        if (b == 0) begin lo_m = '1; hi_m = a; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin lo_m = a; hi_m = 0; end
        else begin
          ia = $signed(a); ib = $signed(b);
          lo_m = 32'(ia / ib); hi_m = 32'(ia % ib);
        end
      end
      3'd4: begin
        if (b == 0) begin lo_m = '1; hi_m = a; end
        else begin lo_m = a / b; hi_m = a % b; end
      end
      3'd5: hi_m = a;
      3'd6: lo_m = a;
      default: ;
    endcase
  endtask

  // Present one instruction and let it load; returns its payload.
  task automatic load_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [PW-1:0] pay);
    int k;
    pay = {$urandom, $urandom};
    in_op = op; in_src0 = a; in_src1 = b; in_payload = pay; in_valid = 1'b1;
    k = 0;
    while (!in_allowin && k < 200) begin tick; k++; end
    chk("allowin_wait", {63'b0, in_allowin}, 64'd1);
    tick;
    // scramble inputs so any use of unregistered inputs shows up
    in_valid = 1'b0; in_op = 3'd7; in_src0 = $urandom; in_src1 = $urandom;
    in_payload = {$urandom, $urandom};
  endtask

  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int stall);
    logic [PW-1:0] pay;
    int lat;
    out_allowin = (stall == 0);
    load_op(op, a, b, pay);
    lat = 0;
    while (!out_valid && lat < 100) begin tick; lat++; end
    chk($sformatf("latency_op%0d", op), 64'(lat), 64'(exp_lat(op)));
    chk("payload", out_payload, pay);
    for (int s = 0; s < stall; s++) begin
      chk("stall_valid", {63'b0, out_valid}, 64'd1);
      chk("stall_payload", out_payload, pay);
      chk("stall_hilo", {hi, lo}, {hi_m, lo_m});
      tick;
    end
    out_allowin = 1'b1;
    tick;
    model_commit(op, a, b);
    chk($sformatf("hi_op%0d", op), 64'(hi), 64'(hi_m));
    chk($sformatf("lo_op%0d", op), 64'(lo), 64'(lo_m));
  endtask

  logic [PW-1:0] fpay;
  logic          seen;
  logic [2:0]    b2b_op [3];
  logic [W-1:0]  b2b_a  [3];
  logic [W-1:0]  b2b_b  [3];
  logic [PW-1:0] b2b_p  [3];
  int            hand_cyc [$];
  logic [PW-1:0] hand_pay [$];
  int            idx;
  logic          h, ld;
  logic [PW-1:0] hp;
  logic [2:0]    rop;
  logic [W-1:0]  ra, rb;

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_op = '0;
    in_src0 = '0; in_src1 = '0; in_payload = '0; out_allowin = 1'b1;
    tick; tick;
    chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("rst_allowin", {63'b0, in_allowin}, 64'd1);
    chk("rst_busy", {63'b0, md_busy}, 64'd0);
    chk("rst_hilo", {hi, lo}, 64'd0);
    rst_n = 1'b1;
    tick;

    // directed arithmetic
    run_op(3'd1, 32'hFFFF_FFFE, 32'd3, 0);
    chk("mult_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
    run_op(3'd2, 32'hFFFF_FFFE, 32'd3, 0);
    chk("multu_const", {hi, lo}, 64'h0000_0002_FFFF_FFFA);
    run_op(3'd3, 32'hFFFF_FFF9, 32'd2, 0);
    chk("div_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(3'd4, 32'd100, 32'd7, 0);
    chk("divu_const", {hi, lo}, {32'd2, 32'd14});
    run_op(3'd4, 32'd5, 32'd0, 0);
    chk("divu0_const", {hi, lo}, {32'd5, 32'hFFFF_FFFF});
    run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    chk("div_ovf_const", {hi, lo}, {32'd0, 32'h8000_0000});
    run_op(3'd3, 32'hFFFF_FFF9, 32'd0, 0);
    run_op(3'd5, 32'h1357_9BDF, 32'h0, 0);
    run_op(3'd6, 32'h2468_ACE0, 32'h0, 0);
    run_op(3'd7, 32'hDEAD_BEEF, 32'd1, 0);
    run_op(3'd0, 32'hDEAD_BEEF, 32'd1, 0);

    // completion while downstream stalls
    run_op(3'd1, 32'd12345, 32'hFFFF_FFF7, 5);

    // flush in the middle of a divide
    out_allowin = 1'b1;
    load_op(3'd3, 32'd1000, 32'd3, fpay);
    repeat (10) tick;
    flush = 1'b1;
    tick;
    flush = 1'b0;
    chk("flush_busy", {63'b0, md_busy}, 64'd0);
    chk("flush_valid", {63'b0, out_valid}, 64'd0);
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin seen |= out_valid; tick; end
    chk("flush_no_out", {63'b0, seen}, 64'd0);
    chk("flush_hilo", {hi, lo}, {hi_m, lo_m});

    // back-to-back MTHI, MULTU, MTLO with in_valid held
    b2b_op[0] = 3'd5; b2b_a[0] = 32'h1234; b2b_b[0] = 32'd0;
    b2b_op[1] = 3'd2; b2b_a[1] = 32'd3;    b2b_b[1] = 32'd4;
    b2b_op[2] = 3'd6; b2b_a[2] = 32'hAB;   b2b_b[2] = 32'd0;
    for (int i = 0; i < 3; i++) b2b_p[i] = {$urandom, $urandom};
    idx = 0;
    in_op = b2b_op[0]; in_src0 = b2b_a[0]; in_src1 = b2b_b[0]; in_payload = b2b_p[0];
    in_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      h = out_valid; hp = out_payload; ld = in_allowin && in_valid;
      if (h) begin hand_cyc.push_back(c); hand_pay.push_back(hp); end
      tick;
      if (ld) begin
        idx++;
        if (idx < 3) begin
          in_op = b2b_op[idx]; in_src0 = b2b_a[idx]; in_src1 = b2b_b[idx]; in_payload = b2b_p[idx];
        end else in_valid = 1'b0;
      end
    end
    for (int i = 0; i < 3; i++) model_commit(b2b_op[i], b2b_a[i], b2b_b[i]);
    chk("b2b_count", 64'(hand_cyc.size()), 64'd3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("b2b_cycle%0d", i), 64'(i < hand_cyc.size() ? hand_cyc[i] : -1),
          64'(i == 0 ? 1 : (i == 1 ? 2 + ML : 3 + ML)));
      chk($sformatf("b2b_pay%0d", i), i < hand_pay.size() ? hand_pay[i] : '1, b2b_p[i]);
    end
    chk("b2b_hilo", {hi, lo}, {hi_m, lo_m});
    chk("b2b_const", {hi, lo}, {32'd0, 32'hAB});

    // random ops against the model
    for (int n = 0; n < 40; n++) begin
      rop = 3'($urandom_range(0, 7));
      ra = $urandom; rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 15));
        default: ;
      endcase
      run_op(rop, ra, rb, $urandom_range(0, 2));
    end

    // reset in the middle of a divide
    load_op(3'd4, 32'hFFFF_0000, 32'd9, fpay);
    repeat (5) tick;
    rst_n = 1'b0;
    tick;
    chk("midrst_busy", {63'b0, md_busy}, 64'd0);
    chk("midrst_valid", {63'b0, out_valid}, 64'd0);
    chk("midrst_allowin", {63'b0, in_allowin}, 64'd1);
    chk("midrst_hilo", {hi, lo}, 64'd0);
    rst_n = 1'b1;
    hi_m = '0; lo_m = '0;
    tick;
    run_op(3'd1, 32'd7, 32'd6, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
